// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and constants for the subtract-based GCD controller.
// Holds the controller state encoding, the datapath width, the default
// watchdog limit with its counter-width derivation, and the mux-select codes.
package gcd_pkg;

    localparam int unsigned GCD_W = 8;

    // Counter width needed to represent 0..max_iter inclusive.
    function automatic int unsigned calc_cw(input int unsigned max_iter);
        return $clog2(max_iter + 1);
    endfunction

    // 254 steps is the worst case for nonzero 8-bit operands (255,1).
    localparam int unsigned DEF_MAX_ITER = 255;
    localparam int unsigned DEF_CW       = calc_cw(DEF_MAX_ITER);

    localparam logic SEL_IN  = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/gcd_if.sv
// gcd_if: control bundle between the GCD controller and its datapath/host.
//   start                      request from the host
//   a_gt_b, a_lt_b, a_eq_b     datapath comparator flags
//   a_ld, b_ld, a_sel, b_sel   datapath load strobes and mux selects
//   output_en                  load datapath out register with B
//   busy, done, err            host handshake
//   iter_count                 last operation's step count (GCD_ITER_COUNT_EN only)
// Modport slave is the controller side, master is the datapath/host side.
interface gcd_if
`ifdef GCD_ITER_COUNT_EN
    #(parameter int unsigned CW = gcd_pkg::DEF_CW)
`endif
    ();

    logic start;
    logic a_gt_b;
    logic a_lt_b;
    logic a_eq_b;
    logic a_ld;
    logic b_ld;
    logic a_sel;
    logic b_sel;
    logic output_en;
    logic busy;
    logic done;
    logic err;
`ifdef GCD_ITER_COUNT_EN
    logic [CW-1:0] iter_count;
`endif

    modport slave (
        input  start, a_gt_b, a_lt_b, a_eq_b,
        output a_ld, b_ld, a_sel, b_sel, output_en, busy, done, err
`ifdef GCD_ITER_COUNT_EN
        , output iter_count
`endif
    );

    modport master (
        output start, a_gt_b, a_lt_b, a_eq_b,
        input  a_ld, b_ld, a_sel, b_sel, output_en, busy, done, err
`ifdef GCD_ITER_COUNT_EN
        , input iter_count
`endif
    );

endinterface

// File: rtl/gcd_iter_counter.sv
// gcd_iter_counter: subtraction-step counter for the GCD watchdog.
//   clk, rst   clock, synchronous active-high reset
//   clr        restart count at 0
//   inc        count one step; ignored once at the limit
//   count      current step count
//   at_max_c   count has reached MAX_ITER (combinational)
module gcd_iter_counter
    import gcd_pkg::*;
#(
    parameter int unsigned MAX_ITER = DEF_MAX_ITER,
    parameter int unsigned CW       = calc_cw(MAX_ITER)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          at_max_c
);

    assign at_max_c = (count == CW'(MAX_ITER));

    // Saturating up-counter; never wraps past MAX_ITER.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !at_max_c) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/gcd_controller.sv
// gcd_controller: control FSM for the 8-bit subtract-based GCD datapath.
//   clk, rst   clock, synchronous active-high reset
//   bus        gcd_if.slave: start and comparator flags in; load/select
//              strobes, output_en, busy/done/err out
// Strobes are combinational from state and flags; busy/done/err decode state.
// A watchdog limits CALC to MAX_ITER subtractions and also rejects malformed
// flag combinations, ending in a done+err pulse.
// Optional: define GCD_ITER_COUNT_EN to add bus.iter_count, the step count of
// the last completed or errored operation.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int unsigned MAX_ITER = DEF_MAX_ITER
) (
    input  logic  clk,
    input  logic  rst,
    gcd_if.slave  bus
);

    localparam int unsigned CW = calc_cw(MAX_ITER);

    state_t          state_q;
    state_t          state_d;
    logic            a_ld_c;
    logic            b_ld_c;
    logic            a_sel_c;
    logic            b_sel_c;
    logic            output_en_c;
    logic            cnt_clr_c;
    logic            cnt_inc_c;
    logic            cnt_at_max_c;
    logic [CW-1:0]   cnt;

    gcd_iter_counter #(
        .MAX_ITER (MAX_ITER),
        .CW       (CW)
    ) u_iter_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_c),
        .inc      (cnt_inc_c),
        .count    (cnt),
        .at_max_c (cnt_at_max_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes.
    always_comb begin
        state_d     = state_q;
        a_ld_c      = 1'b0;
        b_ld_c      = 1'b0;
        a_sel_c     = SEL_IN;
        b_sel_c     = SEL_IN;
        output_en_c = 1'b0;
        cnt_clr_c   = 1'b0;
        cnt_inc_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = LOAD;
                    cnt_clr_c = 1'b1;
                end
            end
            LOAD: begin
                a_ld_c  = 1'b1;
                b_ld_c  = 1'b1;
                state_d = CALC;
            end
            CALC: begin
                // Exactly one flag must be set; anything else is a datapath fault.
                case ({bus.a_gt_b, bus.a_lt_b, bus.a_eq_b})
                    3'b001: begin
                        output_en_c = 1'b1;
                        state_d     = DONE;
                    end
                    3'b100: begin
                        if (cnt_at_max_c) begin
                            state_d = ERR;
                        end else begin
                            a_ld_c    = 1'b1;
                            a_sel_c   = SEL_SUB;
                            cnt_inc_c = 1'b1;
                        end
                    end
                    3'b010: begin
                        if (cnt_at_max_c) begin
                            state_d = ERR;
                        end else begin
                            b_ld_c    = 1'b1;
                            b_sel_c   = SEL_SUB;
                            cnt_inc_c = 1'b1;
                        end
                    end
                    default: state_d = ERR;
                endcase
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef GCD_ITER_COUNT_EN
    logic [CW-1:0] iter_q;

    // Snapshot the step count on entry to DONE/ERR; held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q <= '0;
        end else if (state_q == CALC && (state_d == DONE || state_d == ERR)) begin
            iter_q <= cnt;
        end
    end

    assign bus.iter_count = iter_q;
`endif

    assign bus.a_ld      = a_ld_c;
    assign bus.b_ld      = b_ld_c;
    assign bus.a_sel     = a_sel_c;
    assign bus.b_sel     = b_sel_c;
    assign bus.output_en = output_en_c;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE) || (state_q == ERR);
    assign bus.err       = (state_q == ERR);

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: self-checking bench for gcd_controller driven by a
// behavioural 8-bit subtract datapath; expected results come from a reference
// GCD model pushed into a scoreboard queue at start and popped at done.
module tb_gcd_controller;
    import gcd_pkg::*;

    localparam int unsigned MAXI = DEF_MAX_ITER;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_if bus ();

    gcd_controller #(.MAX_ITER(MAXI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural datapath
    logic [7:0] in1, in2, a_r, b_r, out_r;
    int         flag_ovr;  // 0 = real flags, 1 = gt&lt both high, 2 = no flag

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= 8'd0;
            b_r   <= 8'd0;
            out_r <= 8'd0;
        end else begin
            if (bus.a_ld) a_r <= (bus.a_sel == SEL_SUB) ? a_r - b_r : in1;
            if (bus.b_ld) b_r <= (bus.b_sel == SEL_SUB) ? b_r - a_r : in2;
            if (bus.output_en) out_r <= b_r;
        end
    end

    always_comb begin
        case (flag_ovr)
            1:       {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} = 3'b110;
            2:       {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} = 3'b000;
            default: {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b} = {a_r > b_r, a_r < b_r, a_r == b_r};
        endcase
    end

    typedef struct {
        logic [7:0] out;
        int         iter;
        bit         err;
        int         cycles;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: repeated subtraction with a step limit; error keeps old out.
    function automatic exp_t ref_model(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] prev);
        exp_t e;
        int a, b, n;
        a = int'(x); b = int'(y); n = 0;
        e.err = 1'b0;
        while (a != b) begin
            if (n == int'(MAXI)) begin
                e.err = 1'b1;
                break;
            end
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        e.iter   = n;
        e.cycles = n + 3;
        e.out    = e.err ? prev : 8'(b);
        return e;
    endfunction

    // Start an operation from IDLE; returns at the negedge of cycle 1 (LOAD).
    task automatic drive_start(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        in1 = x;
        in2 = y;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Observe cycles until done; returns at the negedge of the done cycle.
    task automatic wait_done(input int first_cyc, input int load_cyc, input int budget,
                             output int cyc, output bit timed_out, output int oe_cnt,
                             output bit pair_bad, output bit busy_bad);
        cyc = first_cyc; timed_out = 1'b1; oe_cnt = 0; pair_bad = 1'b0; busy_bad = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (bus.output_en) oe_cnt++;
            if (bus.a_ld && bus.b_ld && cyc != load_cyc) pair_bad = 1'b1;
            if (!bus.busy) busy_bad = 1'b1;
            if (bus.done) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    function automatic logic [7:0] out_vec();
        return {bus.a_ld, bus.b_ld, bus.a_sel, bus.b_sel, bus.output_en,
                bus.busy, bus.done, bus.err};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_vec() !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000", out_vec());
        end
`ifdef GCD_ITER_COUNT_EN
        n_checks++;
        if (bus.iter_count !== '0) begin
            n_fail++;
            $display("FAIL reset_iter_count: got %0d expected 0", bus.iter_count);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [7:0] vx[4] = '{8'd12, 8'd9, 8'd255, 8'd0};
        logic [7:0] vy[4] = '{8'd8,  8'd9, 8'd1,   8'd5};
        logic [7:0] prev;
        exp_t e;
        int cyc, oe;
        bit to, pb, bb;
        for (int i = 0; i < 4; i++) begin
            prev = (exp_q.size() == 0 && i == 0) ? 8'd0 : e.out;
            exp_q.push_back(ref_model(vx[i], vy[i], prev));
            drive_start(vx[i], vy[i]);
            wait_done(1, 1, 400, cyc, to, oe, pb, bb);
            e = exp_q.pop_front();
            n_checks++;
            if (to) begin
                n_fail++;
                $display("FAIL vec%0d_timeout: no done within 400 cycles", i);
            end
            n_checks++;
            if (cyc !== e.cycles) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got cycle %0d expected %0d", i, cyc, e.cycles);
            end
            n_checks++;
            if (bus.err !== e.err) begin
                n_fail++;
                $display("FAIL vec%0d_err: got %b expected %b", i, bus.err, e.err);
            end
            n_checks++;
            if (out_r !== e.out) begin
                n_fail++;
                $display("FAIL vec%0d_out: got %0d expected %0d", i, out_r, e.out);
            end
            n_checks++;
            if (oe !== (e.err ? 0 : 1) || pb || bb) begin
                n_fail++;
                $display("FAIL vec%0d_strobes: output_en count %0d pair_bad %b busy_bad %b", i, oe, pb, bb);
            end
`ifdef GCD_ITER_COUNT_EN
            n_checks++;
            if (int'(bus.iter_count) !== e.iter) begin
                n_fail++;
                $display("FAIL vec%0d_iter_count: got %0d expected %0d", i, bus.iter_count, e.iter);
            end
`endif
        end
    endtask

    task automatic test_malformed();
        exp_t e;
        int cyc, oe;
        bit to, pb, bb;
        for (int m = 1; m <= 2; m++) begin
            exp_q.push_back('{out: out_r, iter: 0, err: 1'b1, cycles: 3});
            drive_start(8'd20, 8'd6);
            flag_ovr = m;
            @(negedge clk);  // cycle 2: CALC with bad flags
            n_checks++;
            if (out_vec() !== 8'b0000_0100) begin
                n_fail++;
                $display("FAIL malformed%0d_calc: got %b expected 00000100", m, out_vec());
            end
            wait_done(2, 1, 10, cyc, to, oe, pb, bb);
            flag_ovr = 0;
            e = exp_q.pop_front();
            n_checks++;
            if (to || cyc !== e.cycles || bus.err !== e.err || out_r !== e.out) begin
                n_fail++;
                $display("FAIL malformed%0d_result: cycle %0d err %b out %0d expected cycle %0d err 1 out %0d",
                         m, cyc, bus.err, out_r, e.cycles, e.out);
            end
`ifdef GCD_ITER_COUNT_EN
            n_checks++;
            if (int'(bus.iter_count) !== e.iter) begin
                n_fail++;
                $display("FAIL malformed%0d_iter_count: got %0d expected 0", m, bus.iter_count);
            end
`endif
        end
    endtask

    task automatic test_start_busy();
        exp_t e;
        int cyc, oe;
        bit to, pb, bb;
        exp_q.push_back(ref_model(8'd12, 8'd8, out_r));
        drive_start(8'd12, 8'd8);
        @(negedge clk);
        bus.start = 1'b1;   // cycles 2-3: start while busy
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(4, 1, 10, cyc, to, oe, pb, bb);
        e = exp_q.pop_front();
        n_checks++;
        if (to || cyc !== e.cycles || out_r !== e.out || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy_result: cycle %0d out %0d err %b expected cycle %0d out %0d err 0",
                     cyc, out_r, bus.err, e.cycles, e.out);
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL start_busy_no_queue: busy %b expected 0", bus.busy);
            end
        end
    endtask

    task automatic test_start_held();
        exp_t e;
        int cyc, oe;
        bit to, pb, bb;
        exp_q.push_back(ref_model(8'd9, 8'd9, out_r));
        exp_q.push_back(ref_model(8'd9, 8'd9, out_r));
        @(negedge clk);
        in1 = 8'd9;
        in2 = 8'd9;
        bus.start = 1'b1;
        @(negedge clk);
        wait_done(1, 1, 10, cyc, to, oe, pb, bb);
        e = exp_q.pop_front();
        n_checks++;
        if (to || cyc !== e.cycles || out_r !== e.out) begin
            n_fail++;
            $display("FAIL held_first: cycle %0d out %0d expected cycle %0d out %0d", cyc, out_r, e.cycles, e.out);
        end
        @(negedge clk);  // cycle 4: IDLE
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_idle_gap: busy %b expected 0", bus.busy);
        end
        @(negedge clk);  // cycle 5: LOAD of the re-started op
        n_checks++;
        if ({bus.busy, bus.a_ld, bus.b_ld} !== 3'b111) begin
            n_fail++;
            $display("FAIL held_restart: busy,a_ld,b_ld %b expected 111", {bus.busy, bus.a_ld, bus.b_ld});
        end
        bus.start = 1'b0;
        wait_done(5, 5, 10, cyc, to, oe, pb, bb);
        e = exp_q.pop_front();
        n_checks++;
        if (to || cyc !== e.cycles + 4 || out_r !== e.out) begin
            n_fail++;
            $display("FAIL held_second: cycle %0d out %0d expected cycle %0d out %0d", cyc, out_r, e.cycles + 4, e.out);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int cyc, oe;
        bit to, pb, bb;
        drive_start(8'd12, 8'd8);
        repeat (2) @(negedge clk);  // cycle 3: CALC
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_vec() !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 00000000", out_vec());
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_vec() !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %b expected 00000000", out_vec());
        end
        exp_q.push_back(ref_model(8'd12, 8'd8, out_r));
        drive_start(8'd12, 8'd8);
        wait_done(1, 1, 20, cyc, to, oe, pb, bb);
        e = exp_q.pop_front();
        n_checks++;
        if (to || cyc !== e.cycles || out_r !== e.out || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_rerun: cycle %0d out %0d err %b expected cycle %0d out %0d err 0",
                     cyc, out_r, bus.err, e.cycles, e.out);
        end
`ifdef GCD_ITER_COUNT_EN
        n_checks++;
        if (int'(bus.iter_count) !== e.iter) begin
            n_fail++;
            $display("FAIL reset_mid_iter_count: got %0d expected %0d", bus.iter_count, e.iter);
        end
`endif
    endtask

    initial begin
        bus.start = 1'b0;
        in1       = 8'd0;
        in2       = 8'd0;
        flag_ovr  = 0;
        test_reset();
        test_vectors();
        test_malformed();
        test_start_busy();
        test_start_held();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
